pulse_gen: RTL and testbench
============================

Name: pulse_gen

Overview:
Parametrised, fully synchronous monostable pulse generator, successor to the single-width one-shot. Detects a rising edge on trigger and drives pulse high for a run-time-programmable number of clock cycles. Supports retriggerable and non-retriggerable modes, with done and missed status strobes. Used for timed strobes (LED, bus enables, stall windows) in the processor datapath.

Parameters:
CNT_WIDTH, 5, width of the pulse-length input and down-counter; max pulse length 2^CNT_WIDTH-1 cycles
RETRIG_DEFAULT, 0, unused at reset; documents the expected tie-off value of retrig

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
trigger  input  1  trigger level, assumed synchronous to clk (see optional feature)
width  input  CNT_WIDTH  pulse length in cycles, sampled on an accepted trigger edge
retrig  input  1  1 = retriggerable mode, 0 = one-shot mode; sampled every cycle
pulse  output  1  registered output pulse
remaining  output  CNT_WIDTH  cycles of pulse left, including the current one; 0 when idle
done  output  1  one-cycle strobe when pulse falls
missed  output  1  one-cycle strobe when a trigger edge is ignored

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: pulse=0, remaining=0, done=0, missed=0, FSM=IDLE. The trigger history flop trig_d is set to 1, so a trigger held high through reset does not fire.
- Edge detect: rise = trigger & ~trig_d. trig_d <= trigger every cycle.
- FSM states: IDLE and ACTIVE. pulse==1 exactly when the state is ACTIVE.
- IDLE, rise=1, width!=0:
  - At that same clk edge: state->ACTIVE, pulse<=1, remaining<=width.
  - Latency: pulse is high from the first clk edge that samples trigger high.
- IDLE, rise=1, width==0: no pulse, done=0, missed=0. The event is silently dropped.
- ACTIVE, no rise: remaining decrements by 1 per cycle.
  - When remaining==1, the next edge gives: state->IDLE, pulse<=0, remaining<=0, done<=1 for one cycle.
  - Pulse is therefore high for exactly width cycles.
- width is captured only on an accepted edge. Changes mid-pulse are ignored.
- ACTIVE, rise=1, retrig=1, width!=0:
  - remaining<=width (new value), pulse stays 1, no done.
  - Applies in the last cycle (remaining==1) as well; no gap appears in pulse.
- ACTIVE, rise=1, retrig=1, width==0: treated as no rise; normal countdown.
- ACTIVE, rise=1, retrig=0: edge ignored, missed<=1 for one cycle, countdown continues unchanged.
  - If this coincides with remaining==1, both done and missed are 1 in the same cycle.
  - The generator does not restart; a new edge is required.
- done and missed are registered, high for a single cycle, and never high while reset is asserted.
- reset asserted mid-pulse: all outputs are 0 at the next edge. No done strobe is produced.
- Arithmetic: remaining is unsigned CNT_WIDTH. It never wraps, because decrement occurs only when remaining>=1.

Optional Feature:
Macro PULSE_GEN_SYNC_EN.
- Defined: trigger passes through a 2-flop synchroniser before edge detect, allowing an asynchronous trigger. Latency from trigger to pulse rise is +2 cycles. Synchroniser flops reset to 1 along with trig_d.
- Undefined: trigger feeds edge detect directly (latency 0 as above), and trigger must be synchronous to clk.

Test Plan:
1. Reset, width=4, retrig=0, trigger 0->1 sampled at edge N -> pulse high edges N..N+3 (4 cycles), remaining 4,3,2,1, then 0; done=1 in the cycle pulse falls; missed=0.
2. width=6, retrig=0, second trigger rise at the 3rd active cycle -> pulse stays exactly 6 cycles; missed=1 for one cycle aligned with the ignored edge; single done at end.
3. width=5, retrig=1, second rise at the 4th active cycle (remaining=2), width changed to 3 at that edge -> remaining reloads to 3; total pulse 3+3=6 cycles; no done until the final fall; missed=0.
4. width=0 with a trigger rise in IDLE -> pulse, done, missed all stay 0. Trigger held high across a reset release -> no pulse.
5. width=31 (CNT_WIDTH=5 max), pulse started, reset asserted at remaining=20 -> next edge pulse=0, remaining=0, done=0. A fresh rise afterwards gives a full 31-cycle pulse.
6. With PULSE_GEN_SYNC_EN defined, repeat test 1 -> pulse rises 2 cycles later and is still 4 cycles wide.

Source files
------------

// File: rtl/pulse_gen.sv
// Retriggerable / one-shot monostable pulse generator with done and missed strobes.
// Define PULSE_GEN_SYNC_EN to pass trigger through a 2-flop synchroniser first.
module pulse_gen #(
    parameter int unsigned CNT_WIDTH      = 5,
    parameter int unsigned RETRIG_DEFAULT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] width,
    input  logic                 retrig,
    output logic                 pulse,
    output logic [CNT_WIDTH-1:0] remaining,
    output logic                 done,
    output logic                 missed
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    if (CNT_WIDTH < 1) begin : g_bad_width
        $error("pulse_gen: CNT_WIDTH must be at least 1");
    end
    if (RETRIG_DEFAULT > 1) begin : g_bad_retrig
        $error("pulse_gen: RETRIG_DEFAULT must be 0 or 1");
    end

    logic                 trig_s;
    logic                 trig_hist_q;
    logic                 rise;
    logic [0:0]           state_q,  state_d;
    logic [CNT_WIDTH-1:0] rem_q,    rem_d;
    logic                 done_q,   done_d;
    logic                 missed_q, missed_d;
    logic                 width_nz;

`ifdef PULSE_GEN_SYNC_EN
    logic [1:0] sync_q;

    // Synchroniser resets to 1 so a trigger held high through reset cannot fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], trigger};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger;
`endif

    assign rise     = trig_s & ~trig_hist_q;
    assign width_nz = (width != '0);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        missed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && width_nz) begin
                    state_d = ACTIVE;
                    rem_d   = width;
                end
            end
            default: begin
                if (rise && retrig && width_nz) begin
                    rem_d = width;
                end else begin
                    // A zero-width retrigger counts as no edge; one-shot edges only flag missed.
                    missed_d = rise & ~retrig;
                    if (rem_q == ONE) begin
                        state_d = IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_hist_q <= 1'b1;
            state_q     <= IDLE;
            rem_q       <= '0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            trig_hist_q <= trig_s;
            state_q     <= state_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
        end
    end

    assign pulse     = (state_q == ACTIVE);
    assign remaining = rem_q;
    assign done      = done_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen; expected values are hand-computed per step.
module tb_pulse_gen;

    localparam int unsigned CW = 5;
`ifdef PULSE_GEN_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic          clk;
    logic          reset;
    logic          trigger;
    logic [CW-1:0] width;
    logic          retrig;
    logic          pulse;
    logic [CW-1:0] remaining;
    logic          done;
    logic          missed;

    int checks   = 0;
    int failures = 0;

    pulse_gen #(.CNT_WIDTH(CW), .RETRIG_DEFAULT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .width     (width),
        .retrig    (retrig),
        .pulse     (pulse),
        .remaining (remaining),
        .done      (done),
        .missed    (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ep, input int er, input logic ed, input logic em);
        checks++;
        assert (pulse === ep) else begin
            failures++;
            $error("FAIL %s pulse: got %b expected %b", tag, pulse, ep);
        end
        checks++;
        assert (remaining === CW'(er)) else begin
            failures++;
            $error("FAIL %s remaining: got %0d expected %0d", tag, remaining, er);
        end
        checks++;
        assert (done === ed) else begin
            failures++;
            $error("FAIL %s done: got %b expected %b", tag, done, ed);
        end
        checks++;
        assert (missed === em) else begin
            failures++;
            $error("FAIL %s missed: got %b expected %b", tag, missed, em);
        end
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; width = '0; retrig = 1'b0;
        tick(); tick();
        chk("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("idle", 0, 0, 0, 0);

        // Basic 4-cycle one-shot (with synchroniser latency when enabled)
        width = 5'd4; trigger = 1'b1;
        for (int i = 0; i < int'(LAT); i++) begin
            tick(); chk("t1_lat", 0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); chk("t1_run", 1, 4 - i, 0, 0);
        end
        tick(); chk("t1_done", 0, 0, 1, 0);
        tick(); chk("t1_after", 0, 0, 0, 0);
        trigger = 1'b0;
        for (int i = 0; i < int'(LAT) + 1; i++) tick();
        chk("t1_idle", 0, 0, 0, 0);

`ifndef PULSE_GEN_SYNC_EN
        // One-shot with an ignored edge in the 3rd active cycle
        width = 5'd6; trigger = 1'b1;
        tick(); chk("t2_c1", 1, 6, 0, 0);
        trigger = 1'b0;
        tick(); chk("t2_c2", 1, 5, 0, 0);
        trigger = 1'b1;
        tick(); chk("t2_miss", 1, 4, 0, 1);
        width = 5'd9;
        tick(); chk("t2_c4", 1, 3, 0, 0);
        tick(); chk("t2_c5", 1, 2, 0, 0);
        tick(); chk("t2_c6", 1, 1, 0, 0);
        tick(); chk("t2_done", 0, 0, 1, 0);
        tick(); chk("t2_after", 0, 0, 0, 0);
        trigger = 1'b0;
        tick();

        // Retrigger reloads with the new width, 3+3 cycles total
        retrig = 1'b1; width = 5'd5; trigger = 1'b1;
        tick(); chk("t3_c1", 1, 5, 0, 0);
        trigger = 1'b0;
        tick(); chk("t3_c2", 1, 4, 0, 0);
        tick(); chk("t3_c3", 1, 3, 0, 0);
        width = 5'd3; trigger = 1'b1;
        tick(); chk("t3_reload", 1, 3, 0, 0);
        tick(); chk("t3_c5", 1, 2, 0, 0);
        tick(); chk("t3_c6", 1, 1, 0, 0);
        tick(); chk("t3_done", 0, 0, 1, 0);
        trigger = 1'b0; retrig = 1'b0;
        tick();

        // Ignored edge in the last cycle: done and missed together
        width = 5'd2; trigger = 1'b1;
        tick(); chk("tm_c1", 1, 2, 0, 0);
        trigger = 1'b0;
        tick(); chk("tm_c2", 1, 1, 0, 0);
        trigger = 1'b1;
        tick(); chk("tm_both", 0, 0, 1, 1);
        tick(); chk("tm_norestart", 0, 0, 0, 0);
        trigger = 1'b0;
        tick();

        // Zero width is dropped; trigger held through reset does not fire
        width = '0; trigger = 1'b1;
        tick(); chk("t4_w0a", 0, 0, 0, 0);
        tick(); chk("t4_w0b", 0, 0, 0, 0);
        trigger = 1'b0;
        tick();
        width = 5'd4; trigger = 1'b1; reset = 1'b1;
        tick(); tick(); chk("t4_rst", 0, 0, 0, 0);
        reset = 1'b0;
        tick(); chk("t4_held_a", 0, 0, 0, 0);
        tick(); chk("t4_held_b", 0, 0, 0, 0);
        trigger = 1'b0;
        tick();

        // Max width, reset mid-pulse, then a full 31-cycle pulse
        width = 5'd31; trigger = 1'b1;
        tick(); chk("t5_c1", 1, 31, 0, 0);
        trigger = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick(); chk("t5_pre", 1, 31 - i, 0, 0);
        end
        reset = 1'b1;
        tick(); chk("t5_rst", 0, 0, 0, 0);
        reset = 1'b0;
        tick(); chk("t5_post", 0, 0, 0, 0);
        trigger = 1'b1;
        for (int i = 0; i < 31; i++) begin
            tick(); chk("t5_full", 1, 31 - i, 0, 0);
        end
        tick(); chk("t5_done", 0, 0, 1, 0);
        trigger = 1'b0;
        tick(); chk("t5_idle", 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
